// File: rtl/rng_health_pkg.sv
// Shared types, widths and helpers for the RNG health monitor.
package rng_health_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_HEALTHY  = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_ALARM    = 2'd3
  } health_state_e;

  localparam int CNT_W     = 8;
  localparam int BLK_W     = 16;
  localparam int WIN_CNT_W = 6;

  function automatic logic [WIN_CNT_W-1:0] popcount32(input logic [31:0] v);
    logic [WIN_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {{(WIN_CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [BLK_W-1:0] sat_inc_blk(input logic [BLK_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rng_health_monitor_fail_window.sv
// Sliding window of the last WIN_LEN verdicts (1 = fail) with a registered fail count.
module fail_window
  import rng_health_pkg::*;
#(
  parameter int WIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 bit_in,
  input  logic                 clr,
  output logic [WIN_CNT_W-1:0] win_fails,
  output logic [WIN_CNT_W-1:0] win_next
);

  logic [WIN_LEN-1:0]   window_q, window_d;
  logic [31:0]          padded;
  logic [WIN_CNT_W-1:0] win_fails_q;

  always_comb begin
    window_d = window_q;
    if (clr)           window_d = '0;
    else if (shift_en) window_d = {window_q[WIN_LEN-2:0], bit_in};
    padded = '0;
    padded[WIN_LEN-1:0] = window_d;
    win_next = popcount32(padded);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_q    <= '0;
      win_fails_q <= '0;
    end else begin
      window_q    <= window_d;
      win_fails_q <= win_next;
    end
  end

  assign win_fails = win_fails_q;

endmodule

// File: rtl/rng_health_monitor.sv
// Health FSM over block-test verdicts: warm-up discard, consecutive/windowed fail tracking,
// rng_ok gate for the entropy consumer and a sticky alarm.
module rng_health_monitor
  import rng_health_pkg::*;
#(
  parameter int WARMUP_BLOCKS = 1,
  parameter int MAX_CONSEC    = 3,
  parameter int WIN_LEN       = 16,
  parameter int MAX_WIN_FAILS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_done,
  input  logic        pass,
  input  logic        clr_alarm,
  output logic        rng_ok,
  output logic        alarm,
  output logic [1:0]  state,
  output logic [7:0]  consec_fails,
  output logic [5:0]  win_fails,
  output logic [15:0] blk_count
);

  localparam logic [CNT_W-1:0]     WARM_L    = CNT_W'(WARMUP_BLOCKS);
  localparam logic [CNT_W-1:0]     CONSEC_L  = CNT_W'(MAX_CONSEC);
  localparam logic [WIN_CNT_W-1:0] MAX_WIN_L = WIN_CNT_W'(MAX_WIN_FAILS);

  // Handshake: blk_done is a single-cycle valid with no back-pressure; pass is only
  // meaningful while blk_done is high, and every strobe is consumed in that cycle.
  health_state_e        state_q, state_d;
  logic [CNT_W-1:0]     warm_q, warm_d, consec_q, consec_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic                 rng_ok_q, rng_ok_d, alarm_q, alarm_d;
  logic                 clear_fire, win_shift;
  logic [WIN_CNT_W-1:0] win_next, win_fails_w;

  // A clear in ALARM takes priority and swallows any verdict arriving alongside it.
  assign clear_fire = clr_alarm && (state_q == ST_ALARM);
  assign win_shift  = blk_done && !clear_fire && (state_q != ST_WARMUP);

  fail_window #(.WIN_LEN(WIN_LEN)) u_fail_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (win_shift),
    .bit_in   (~pass),
    .clr      (clear_fire),
    .win_fails(win_fails_w),
    .win_next (win_next)
  );

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    consec_d = consec_q;
    blk_d    = blk_q;
    if (clear_fire) begin
      state_d  = ST_WARMUP;
      warm_d   = WARM_L;
      consec_d = '0;
    end else if (blk_done) begin
      if (state_q == ST_WARMUP) begin
        warm_d = warm_q - 1'b1;
        if (warm_q == CNT_W'(1)) state_d = ST_HEALTHY;
      end else begin
        consec_d = pass ? '0 : sat_inc_cnt(consec_q);
        blk_d    = sat_inc_blk(blk_q);
        if (state_q != ST_ALARM) begin
          if (consec_d >= CONSEC_L || win_next > MAX_WIN_L) state_d = ST_ALARM;
          else if (consec_d != '0)                           state_d = ST_DEGRADED;
          else                                               state_d = ST_HEALTHY;
        end
      end
    end
    rng_ok_d = (state_d == ST_HEALTHY);
    alarm_d  = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WARMUP;
      warm_q   <= WARM_L;
      consec_q <= '0;
      blk_q    <= '0;
      rng_ok_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      consec_q <= consec_d;
      blk_q    <= blk_d;
      rng_ok_q <= rng_ok_d;
      alarm_q  <= alarm_d;
    end
  end

  assign state        = state_q;
  assign rng_ok       = rng_ok_q;
  assign alarm        = alarm_q;
  assign consec_fails = consec_q;
  assign win_fails    = win_fails_w;
  assign blk_count    = blk_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Scoreboard bench for rng_health_monitor against a queue-based behavioural model.
module tb_rng_health_monitor;

  localparam int WARMUP_BLOCKS = 1;
  localparam int MAX_CONSEC    = 3;
  localparam int WIN_LEN       = 16;
  localparam int MAX_WIN_FAILS = 4;
  localparam int W             = 34;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, blk_done = 1'b0, pass = 1'b0, clr_alarm = 1'b0;
  logic        rng_ok, alarm;
  logic [1:0]  state;
  logic [7:0]  consec_fails;
  logic [5:0]  win_fails;
  logic [15:0] blk_count;

  rng_health_monitor #(
    .WARMUP_BLOCKS(WARMUP_BLOCKS), .MAX_CONSEC(MAX_CONSEC),
    .WIN_LEN(WIN_LEN), .MAX_WIN_FAILS(MAX_WIN_FAILS)
  ) dut (
    .clk(clk), .rst(rst), .blk_done(blk_done), .pass(pass), .clr_alarm(clr_alarm),
    .rng_ok(rng_ok), .alarm(alarm), .state(state), .consec_fails(consec_fails),
    .win_fails(win_fails), .blk_count(blk_count)
  );

  // reference model: 0=WARMUP 1=HEALTHY 2=DEGRADED 3=ALARM
  int m_state, m_warm, m_consec, m_blk;
  int m_hist[$];

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int m_winf();
    int s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s;
  endfunction

  function automatic void model_step(input bit b, input bit p, input bit c, input bit r);
    if (r) begin
      m_state = 0; m_warm = WARMUP_BLOCKS; m_consec = 0; m_blk = 0; m_hist.delete();
      return;
    end
    if (c && m_state == 3) begin
      m_state = 0; m_warm = WARMUP_BLOCKS; m_consec = 0; m_hist.delete();
      return;
    end
    if (!b) return;
    if (m_state == 0) begin
      m_warm--;
      if (m_warm == 0) m_state = 1;
      return;
    end
    m_hist.push_back(p ? 0 : 1);
    if (m_hist.size() > WIN_LEN) void'(m_hist.pop_front());
    m_consec = p ? 0 : ((m_consec < 255) ? m_consec + 1 : 255);
    m_blk    = (m_blk < 65535) ? m_blk + 1 : 65535;
    if (m_state != 3) begin
      if (m_consec >= MAX_CONSEC || m_winf() > MAX_WIN_FAILS) m_state = 3;
      else if (m_consec > 0) m_state = 2;
      else m_state = 1;
    end
  endfunction

  function automatic logic [W-1:0] model_snapshot();
    logic [1:0] s;
    s = 2'(m_state);
    return {s, (m_state == 1), (m_state == 3), 8'(m_consec), 6'(m_winf()), 16'(m_blk)};
  endfunction

  // driver: inputs change on negedge, model advances just after the posedge
  task automatic step(input bit b, input bit p, input bit c, input bit r);
    @(negedge clk);
    blk_done = b; pass = p; clr_alarm = c; rst = r;
    @(posedge clk);
    #1;
    model_step(b, p, c, r);
    exp_q.push_back(model_snapshot());
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, rng_ok, alarm, consec_fails, win_fails, blk_count};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL snapshot t=%0t got state=%0d ok=%0b alarm=%0b consec=%0d win=%0d blk=%0d want state=%0d ok=%0b alarm=%0b consec=%0d win=%0d blk=%0d",
                 $time, act_v[33:32], act_v[31], act_v[30], act_v[29:22], act_v[21:16], act_v[15:0],
                 exp_v[33:32], exp_v[31], exp_v[30], exp_v[29:22], exp_v[21:16], exp_v[15:0]);
      end
    end
  end

  initial begin
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);
    // warm-up discard of a failing verdict
    step(1, 0, 0, 0);
    // pass, fail, pass
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    // three consecutive fails, then passes in ALARM
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(0, 0, 0, 0); step(1, 1, 0, 0);
    // alternating fail/pass trips the window limit
    step(0, 0, 0, 1); step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0); step(1, 1, 0, 0);
    end
    // clear coinciding with a verdict, then warm-up again
    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    // clear outside ALARM is ignored
    step(0, 0, 1, 0); step(1, 0, 1, 0);
    // reset in DEGRADED with two fails outstanding
    step(1, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 0);
    // blk_count saturation
    step(1, 1, 0, 0);
    for (int i = 0; i < 70000; i++) step(1, 1, 0, 0);
    // consec_fails saturation
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
